// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin arbiter onto a single downstream bus.
// Registered bus request/payload, combinational completion strobes, watchdog abort.
module bus_arbiter_rr #(
  parameter int TIMEOUT    = 255,
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [3:0]   i_m_request,
  input  logic [3:0]   i_m_rw,
  input  logic [127:0] i_m_address,
  input  logic [127:0] i_m_wdata,
  output logic [3:0]   o_m_ready,
  output logic [31:0]  o_m_rdata,
  output logic         o_m_error,
  output logic         o_bus_request,
  output logic         o_bus_rw,
  output logic [31:0]  o_bus_address,
  output logic [31:0]  o_bus_wdata,
  input  logic         i_bus_ready,
  input  logic [31:0]  i_bus_rdata,
  output logic [1:0]   o_grant,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ABORT  = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  grant, grant_nxt;
  logic [15:0] wd_cnt, wd_cnt_nxt;
  logic        bus_req, bus_req_nxt;
  logic        bus_rw, bus_rw_nxt;
  logic [31:0] bus_addr, bus_addr_nxt;
  logic [31:0] bus_wdata, bus_wdata_nxt;
  logic [1:0]  winner;
  logic [1:0]  idx;
  logic        found;

  // Rotating priority search starting at ptr, wrapping 3 -> 0.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && i_m_request[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state, bus payload capture, watchdog and master-side outputs.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_nxt     = grant;
    wd_cnt_nxt    = wd_cnt;
    bus_req_nxt   = bus_req;
    bus_rw_nxt    = bus_rw;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    o_m_ready     = 4'b0000;
    o_m_error     = 1'b0;
    o_m_rdata     = i_bus_rdata;
    o_busy        = 1'b0;
    unique case (state)
      IDLE: begin
        bus_req_nxt = 1'b0;
        if (|i_m_request) begin
          grant_nxt     = winner;
          bus_req_nxt   = 1'b1;
          bus_rw_nxt    = i_m_rw[winner];
          bus_addr_nxt  = i_m_address[{winner, 5'd0} +: 32];
          bus_wdata_nxt = i_m_wdata[{winner, 5'd0} +: 32];
          wd_cnt_nxt    = 16'd0;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        o_busy           = 1'b1;
        o_m_ready[grant] = i_bus_ready & i_m_request[grant];
        if (i_bus_ready) begin
          bus_req_nxt = 1'b0;
          ptr_nxt     = grant + 2'd1;
          state_nxt   = IDLE;
        end else if (TIMEOUT_EN && wd_cnt == TO_LAST) begin
          bus_req_nxt = 1'b0;
          state_nxt   = ABORT;
        end else if (wd_cnt != 16'hFFFF) begin
          wd_cnt_nxt = wd_cnt + 16'd1;
        end
      end
      ABORT: begin
        o_busy           = 1'b1;
        o_m_error        = 1'b1;
        o_m_rdata        = 32'd0;
        o_m_ready[grant] = i_m_request[grant];
        ptr_nxt          = grant + 2'd1;
        state_nxt        = IDLE;
      end
      default: begin
        bus_req_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
    // A transaction caught by reset is abandoned without a strobe.
    if (i_reset) begin
      o_m_ready = 4'b0000;
      o_m_error = 1'b0;
      o_busy    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Arbitration pointer, grant, watchdog and registered bus side.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ptr       <= 2'd0;
      grant     <= 2'd0;
      wd_cnt    <= 16'd0;
      bus_req   <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else begin
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      wd_cnt    <= wd_cnt_nxt;
      bus_req   <= bus_req_nxt;
      bus_rw    <= bus_rw_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

  assign o_grant       = grant;
  assign o_bus_request = bus_req;
  assign o_bus_rw      = bus_rw;
  assign o_bus_address = bus_addr;
  assign o_bus_wdata   = bus_wdata;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with TIMEOUT=4.
// Inputs change #1 after a rising edge; outputs are checked #1 later.
module tb_bus_arbiter_rr;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [3:0]   i_m_request;
  logic [3:0]   i_m_rw;
  logic [127:0] i_m_address;
  logic [127:0] i_m_wdata;
  logic [3:0]   o_m_ready;
  logic [31:0]  o_m_rdata;
  logic         o_m_error;
  logic         o_bus_request;
  logic         o_bus_rw;
  logic [31:0]  o_bus_address;
  logic [31:0]  o_bus_wdata;
  logic         i_bus_ready;
  logic [31:0]  i_bus_rdata;
  logic [1:0]   o_grant;
  logic         o_busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] g;
  logic [3:0] exp_rdy;

  bus_arbiter_rr #(
    .TIMEOUT    (4),
    .TIMEOUT_EN (1'b1)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_m_request   (i_m_request),
    .i_m_rw        (i_m_rw),
    .i_m_address   (i_m_address),
    .i_m_wdata     (i_m_wdata),
    .o_m_ready     (o_m_ready),
    .o_m_rdata     (o_m_rdata),
    .o_m_error     (o_m_error),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .o_grant       (o_grant),
    .o_busy        (o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_m_request = 4'b0000;
    i_m_rw      = 4'b0000;
    i_m_address = '0;
    i_m_wdata   = '0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    tick();
    tick();
    #1;
    chk("rst_bus_req", 32'(o_bus_request), 32'd0);
    chk("rst_grant",   32'(o_grant),       32'd0);
    chk("rst_busy",    32'(o_busy),        32'd0);
    chk("rst_ready",   32'(o_m_ready),     32'd0);
    chk("rst_error",   32'(o_m_error),     32'd0);
    chk("rst_addr",    o_bus_address,      32'd0);
    chk("rst_wdata",   o_bus_wdata,        32'd0);
    chk("rst_rw",      32'(o_bus_rw),      32'd0);

    // Single read by master 2.
    i_reset = 1'b0;
    i_m_request = 4'b0100;
    i_m_address[64 +: 32] = 32'h0000_1000;
    #1;
    chk("rd_req_lat0", 32'(o_bus_request), 32'd0);
    tick();
    chk("rd_bus_req",  32'(o_bus_request), 32'd1);
    chk("rd_grant",    32'(o_grant),       32'd2);
    chk("rd_addr",     o_bus_address,      32'h0000_1000);
    chk("rd_rw",       32'(o_bus_rw),      32'd0);
    chk("rd_busy",     32'(o_busy),        32'd1);
    chk("rd_rdy_a1",   32'(o_m_ready),     32'd0);
    tick();
    chk("rd_rdy_a2",   32'(o_m_ready),     32'd0);
    tick();
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hCAFE_BABE;
    #1;
    chk("rd_ready",    32'(o_m_ready),     32'b0100);
    chk("rd_rdata",    o_m_rdata,          32'hCAFE_BABE);
    chk("rd_error",    32'(o_m_error),     32'd0);
    tick();
    i_m_request = 4'b0000;
    i_bus_ready = 1'b0;
    #1;
    chk("rd_idle_req", 32'(o_bus_request), 32'd0);
    chk("rd_idle_bsy", 32'(o_busy),        32'd0);

    // Write by master 1; payload changes during ACCESS.
    i_m_request = 4'b0010;
    i_m_rw      = 4'b0010;
    i_m_address[32 +: 32] = 32'h0000_0020;
    i_m_wdata[32 +: 32]   = 32'hDEAD_BEEF;
    tick();
    i_m_wdata[32 +: 32]   = 32'h0;
    i_m_rw                = 4'b0000;
    i_m_address[32 +: 32] = 32'h0000_0FFF;
    #1;
    chk("wr_grant",    32'(o_grant),       32'd1);
    chk("wr_wdata1",   o_bus_wdata,        32'hDEAD_BEEF);
    chk("wr_rw1",      32'(o_bus_rw),      32'd1);
    chk("wr_addr1",    o_bus_address,      32'h0000_0020);
    tick();
    i_bus_ready = 1'b1;
    #1;
    chk("wr_wdata2",   o_bus_wdata,        32'hDEAD_BEEF);
    chk("wr_rw2",      32'(o_bus_rw),      32'd1);
    chk("wr_ready",    32'(o_m_ready),     32'b0010);
    tick();
    i_m_request = 4'b0000;
    i_bus_ready = 1'b0;
    #1;

    // Timeout: master 0 served, bus never answers, master 1 waiting.
    i_m_request = 4'b0011;
    i_bus_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("to_bus_req", 32'(o_bus_request), 32'd1);
      chk("to_grant",   32'(o_grant),       32'd0);
      chk("to_no_rdy",  32'(o_m_ready),     32'd0);
      chk("to_no_err",  32'(o_m_error),     32'd0);
    end
    tick();
    chk("ab_bus_req",  32'(o_bus_request), 32'd0);
    chk("ab_ready",    32'(o_m_ready),     32'b0001);
    chk("ab_error",    32'(o_m_error),     32'd1);
    chk("ab_rdata",    o_m_rdata,          32'd0);
    chk("ab_busy",     32'(o_busy),        32'd1);
    i_m_request = 4'b0010;
    tick();
    chk("ab_idle_err", 32'(o_m_error),     32'd0);
    chk("ab_idle_bsy", 32'(o_busy),        32'd0);
    chk("ab_rdata_pt", o_m_rdata,          32'h1234_5678);
    tick();
    chk("ab_next_gnt", 32'(o_grant),       32'd1);
    i_bus_ready = 1'b1;
    #1;
    chk("ab_next_rdy", 32'(o_m_ready),     32'b0010);
    tick();
    i_m_request = 4'b0000;
    i_bus_ready = 1'b0;
    #1;

    // Ready on the last permitted ACCESS cycle wins over the timeout.
    i_m_request = 4'b1000;
    tick();
    chk("col_grant",   32'(o_grant),       32'd3);
    tick();
    tick();
    tick();
    i_bus_ready = 1'b1;
    #1;
    chk("col_ready",   32'(o_m_ready),     32'b1000);
    chk("col_error",   32'(o_m_error),     32'd0);
    tick();
    chk("col_idle_bs", 32'(o_busy),        32'd0);
    chk("col_idle_er", 32'(o_m_error),     32'd0);
    chk("col_idle_rq", 32'(o_bus_request), 32'd0);
    i_m_request = 4'b0000;
    i_bus_ready = 1'b0;
    #1;

    // Move the pointer off 0, then reset in the middle of an ACCESS.
    i_m_request = 4'b0001;
    tick();
    i_bus_ready = 1'b1;
    #1;
    chk("pre_ready",   32'(o_m_ready),     32'b0001);
    tick();
    i_m_request = 4'b0100;
    i_bus_ready = 1'b0;
    i_m_address[64 +: 32] = 32'h0000_2222;
    i_m_wdata[64 +: 32]   = 32'h5555_AAAA;
    i_m_rw      = 4'b0100;
    tick();
    chk("mr_grant",    32'(o_grant),       32'd2);
    tick();
    i_reset     = 1'b1;
    i_bus_ready = 1'b1;
    #1;
    chk("mr_ready",    32'(o_m_ready),     32'd0);
    chk("mr_busy",     32'(o_busy),        32'd0);
    chk("mr_error",    32'(o_m_error),     32'd0);
    tick();
    chk("mr_bus_req",  32'(o_bus_request), 32'd0);
    chk("mr_grant0",   32'(o_grant),       32'd0);
    chk("mr_addr",     o_bus_address,      32'd0);
    chk("mr_wdata",    o_bus_wdata,        32'd0);
    chk("mr_rw",       32'(o_bus_rw),      32'd0);

    // All four request continuously; bus answers in the first ACCESS cycle.
    i_reset     = 1'b0;
    i_m_request = 4'b1111;
    i_m_rw      = 4'b0000;
    i_bus_ready = 1'b1;
    i_m_address[0  +: 32] = 32'h0000_0100;
    i_m_address[32 +: 32] = 32'h0000_0200;
    i_m_address[64 +: 32] = 32'h0000_0300;
    i_m_address[96 +: 32] = 32'h0000_0400;
    #1;
    chk("rr_start_rq", 32'(o_bus_request), 32'd0);
    for (int t = 0; t < 5; t++) begin
      g = 2'(t);
      exp_rdy = 4'b0001 << g;
      tick();
      chk("rr_grant",  32'(o_grant),       32'(g));
      chk("rr_ready",  32'(o_m_ready),     32'(exp_rdy));
      chk("rr_addr",   o_bus_address,      32'h100 * (32'(g) + 32'd1));
      tick();
      chk("rr_gap_bsy", 32'(o_busy),       32'd0);
      chk("rr_gap_req", 32'(o_bus_request), 32'd0);
      chk("rr_gap_rdy", 32'(o_m_ready),    32'd0);
    end
    i_m_request = 4'b0000;
    i_bus_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter TIMEOUT, default 255: number of ACCESS cycles without i_bus_ready before the transaction is aborted; legal range 2..65535.
REQ-002 Parameter TIMEOUT_EN, default 1: 1 enables the watchdog; 0 disables it, and ACCESS waits indefinitely.
REQ-003 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_m_request  in  4  per-master request; master k uses bit k and holds it until its ready.
REQ-006 i_m_rw  in  4  per-master direction; 1 = write, 0 = read.
REQ-007 i_m_address  in  128  master k address in bits [32k+31:32k].
REQ-008 i_m_wdata  in  128  master k write data in bits [32k+31:32k].
REQ-009 o_m_ready  out  4  per-master one-cycle completion strobe.
REQ-010 o_m_rdata  out  32  read data shared by all masters; equals i_bus_rdata, or 0 in ABORT.
REQ-011 o_m_error  out  1  high together with the o_m_ready strobe of an aborted transaction.
REQ-012 o_bus_request, o_bus_rw  out  1 each  registered downstream request and direction.
REQ-013 o_bus_address, o_bus_wdata  out  32 each  registered downstream address and write data.
REQ-014 i_bus_ready  in  1  downstream completion; i_bus_rdata  in  32  downstream read data.
REQ-015 o_grant  out  2  index of the master being served; o_busy  out  1  high in ACCESS or ABORT.

Function
REQ-016 FSM states: IDLE, ACCESS, ABORT; any other encoding goes to IDLE on the next edge.
REQ-017 IDLE, no request: o_bus_request is 0 and the state holds.
REQ-018 IDLE, any request: winner = first set bit of i_m_request searched upward from pointer ptr, wrapping 3->0.
REQ-019 On that edge: o_grant <= winner; o_bus_request <= 1; bus address, wdata and rw latched from the winner; state <= ACCESS; watchdog count <= 0.
REQ-020 Grant-to-bus latency: exactly one cycle from the request being sampled in IDLE to o_bus_request=1.
REQ-021 Bus address, wdata and rw stay frozen through ACCESS, even if the master changes its inputs.
REQ-022 ACCESS: o_m_ready[o_grant] = i_bus_ready AND i_m_request[o_grant], combinationally; all other ready bits are 0.
REQ-023 ACCESS with i_bus_ready=1: o_bus_request <= 0; state <= IDLE; ptr <= o_grant+1 mod 4.
REQ-024 Master drops its request mid-ACCESS: the bus transaction still runs to i_bus_ready, and no ready strobe is issued to that master.
REQ-025 ACCESS without i_bus_ready: watchdog count increments by 1 per cycle (16-bit, saturating).
REQ-026 Watchdog trip: when the count equals TIMEOUT-1 and i_bus_ready=0, with TIMEOUT_EN=1: o_bus_request <= 0; state <= ABORT.
REQ-027 i_bus_ready and the timeout in the same cycle: i_bus_ready wins and the transaction completes normally.
REQ-028 ABORT lasts one cycle: o_m_ready[o_grant]=1 only if that master's request is still high; o_m_error=1; o_m_rdata=0; then state <= IDLE and ptr <= o_grant+1.
REQ-029 o_m_error is 0 in every state except ABORT.
REQ-030 After a completion the arbiter always passes through IDLE, so there is at least one idle cycle between two bus transactions.
REQ-031 Fairness: with all four masters requesting continuously, grants follow 0,1,2,3,0,... and no master waits more than three transactions.

Reset
REQ-032 While i_reset=1: state=IDLE; ptr=0; o_grant=0; watchdog count=0; o_bus_request=0; o_bus_rw=0; o_bus_address=0; o_bus_wdata=0.
REQ-033 While i_reset=1, o_m_ready=0, o_m_error=0 and o_busy=0.
REQ-034 Reset asserted mid-ACCESS or mid-ABORT abandons the transaction with no ready strobe; o_bus_request is 0 from the next edge.
REQ-035 Initial (power-up) register values equal the reset values.

Verification
REQ-036 Single read: master 2 reads 0x1000; bus ready after 3 cycles with rdata 0xCAFEBABE -> o_bus_request rises 1 cycle after the request; o_m_ready=4'b0100 for one cycle; o_m_rdata=0xCAFEBABE; o_grant=2.
REQ-037 Round-robin: all four request from reset; bus ready 1 cycle after each request -> grant order 0,1,2,3,0, with one IDLE cycle between each transaction.
REQ-038 Write integrity: master 1 writes 0xDEADBEEF to 0x20; master 1 changes wdata to 0 during ACCESS -> o_bus_wdata stays 0xDEADBEEF and o_bus_rw=1 for the whole transaction.
REQ-039 Timeout: TIMEOUT=4; master 0 requests; bus never ready -> o_bus_request high for 4 cycles; then one ABORT cycle with o_m_ready=4'b0001, o_m_error=1, o_m_rdata=0; next grant goes to master 1 if it is requesting.
REQ-040 Collision at the limit: TIMEOUT=4; i_bus_ready arrives on the 4th ACCESS cycle -> normal completion, o_m_error=0.
REQ-041 Reset mid-ACCESS: assert i_reset during the 2nd ACCESS cycle -> no ready strobe; all outputs at reset values on the next edge; ptr=0, so master 0 is served first after release.
